// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and baud divider arithmetic used by the receiver and the serializer.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

   localparam logic [3:0] OS_MID  = 4'd7;
   localparam logic [3:0] OS_LAST = 4'd15;

   // Clocks per 16x oversampling tick, rounded to nearest.
   function automatic int unsigned calc_div(input int unsigned freq, input int unsigned baud);
      return (freq + 8 * baud) / (16 * baud);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x baud tick generator: one-cycle tick every DIV clocks, phase restartable.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = cnt_width(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (restart || cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: 16x oversampled deserializer with start/stop validation and
// a one-entry valid/ready holding register.
module uart_rx_deser
   import uart_pkg::*;
#(
   parameter int unsigned frequency  = 66000000,
   parameter int unsigned baudrate   = 115200,
   parameter int unsigned data_width = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   output logic [data_width-1:0] rdata,
   output logic                  rvalid,
   input  logic                  rready,
   output logic                  ferr,
   output logic                  ovr,
   output logic                  busy
);

   localparam int unsigned DIV = calc_div(frequency, baudrate);
   localparam logic [3:0] BIT_LAST = 4'(data_width - 1);

   logic                  rx_meta, rxs;
   logic                  tick, restart, mid;
   rx_state_t             state, state_d;
   logic [3:0]            os, os_d;
   logic [3:0]            bitcnt, bitcnt_d;
   logic [data_width-1:0] shreg, shreg_d;
   logic [data_width-1:0] rdata_d;
   logic                  rvalid_d, ferr_d, ovr_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   assign mid = tick && (os == OS_MID);

   always_comb begin
      state_d  = state;
      os_d     = os;
      bitcnt_d = bitcnt;
      shreg_d  = shreg;
      rdata_d  = rdata;
      rvalid_d = rvalid;
      ferr_d   = 1'b0;
      ovr_d    = 1'b0;
      restart  = 1'b0;

      if (tick) begin
         os_d = (os == OS_LAST) ? '0 : os + 4'd1;
      end
      if (rvalid && rready) begin
         rvalid_d = 1'b0;
      end

      case (state)
         ST_IDLE: begin
            if (!rxs) begin
               state_d  = ST_START;
               os_d     = '0;
               bitcnt_d = '0;
               restart  = 1'b1;
            end
         end
         ST_START: begin
            if (mid) begin
               state_d = rxs ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (mid) begin
               shreg_d  = {rxs, shreg[data_width-1:1]};
               bitcnt_d = bitcnt + 4'd1;
               if (bitcnt == BIT_LAST) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (mid) begin
               if (rxs) begin
                  // A consumer accepting in the same cycle frees the slot for the new frame.
                  state_d = ST_IDLE;
                  if (!rvalid || rready) begin
                     rdata_d  = shreg;
                     rvalid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (rxs) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         os     <= '0;
         bitcnt <= '0;
         shreg  <= '0;
         rdata  <= '0;
         rvalid <= 1'b0;
         ferr   <= 1'b0;
         ovr    <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_d;
         os     <= os_d;
         bitcnt <= bitcnt_d;
         shreg  <= shreg_d;
         rdata  <= rdata_d;
         rvalid <= rvalid_d;
         ferr   <= ferr_d;
         ovr    <= ovr_d;
         busy   <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed and randomized bench for uart_rx_deser at DIV = 1 (16 clocks/bit),
// checked against a frame-level holding-register model.
module tb_uart_rx_deser;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rready;
   logic [7:0] rdata;
   logic       rvalid, ferr, ovr, busy;

   int tests = 0;
   int fails = 0;

   int cyc = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   int rise_cyc = -1;
   int frame_start_cyc = 0;
   logic rv_prev = 1'b0;

   // frame-level reference model of the holding register
   logic       m_valid = 1'b0;
   logic [7:0] m_data = 8'h00;
   int         m_ferr = 0;
   int         m_ovr = 0;

   uart_rx_deser #(
      .frequency  (1843200),
      .baudrate   (115200),
      .data_width (8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .rx     (rx),
      .rdata  (rdata),
      .rvalid (rvalid),
      .rready (rready),
      .ferr   (ferr),
      .ovr    (ovr),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (ferr) ferr_cnt++;
      if (ovr) ovr_cnt++;
      if (rvalid && !rv_prev) rise_cyc = cyc;
      rv_prev = rvalid;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one 8N1 frame (160 clocks). acc >= 0 raises rready for exactly that clock index.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int acc);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      frame_start_cyc = cyc;
      for (int k = 0; k < 160; k++) begin
         rx = bits[k/16];
         if (acc >= 0) rready = (k == acc);
         @(posedge clk);
         #1;
      end
      rx = 1'b1;
   endtask

   task automatic model_frame(input logic [7:0] d, input logic good, input logic rdy);
      if (!good) m_ferr++;
      else if (!m_valid || rdy) begin
         m_data  = d;
         m_valid = 1'b1;
      end else m_ovr++;
   endtask

   task automatic consume();
      rready = 1'b1;
      @(posedge clk);
      #1;
      rready = 1'b0;
      m_valid = 1'b0;
   endtask

   initial begin
      int busy_low;
      int waited;
      logic saw_busy;
      logic [7:0] d;
      logic good;
      int gap;

      rst = 1'b0;
      rx = 1'b1;
      rready = 1'b0;
      idle(3);
      check("reset_rdata", {24'd0, rdata}, 32'h0);
      check("reset_rvalid", {31'd0, rvalid}, 32'h0);
      check("reset_ferr", {31'd0, ferr}, 32'h0);
      check("reset_ovr", {31'd0, ovr}, 32'h0);
      check("reset_busy", {31'd0, busy}, 32'h0);
      rst = 1'b1;
      idle(5);

      // single frame and latency
      send_frame(8'h55, 1'b1, -1);
      model_frame(8'h55, 1'b1, 1'b0);
      check("t1_rvalid", {31'd0, rvalid}, {31'd0, m_valid});
      check("t1_rdata", {24'd0, rdata}, {24'd0, m_data});
      check("t1_lat_ok", ((rise_cyc - frame_start_cyc) >= 152 && (rise_cyc - frame_start_cyc) <= 158) ? 32'd1 : 32'd0, 32'd1);
      check("t1_ferr", ferr_cnt, m_ferr);
      check("t1_ovr", ovr_cnt, m_ovr);
      consume();
      check("t1_cleared", {31'd0, rvalid}, 32'h0);

      // back-to-back with accept on completion of second frame
      send_frame(8'hA3, 1'b1, -1);
      model_frame(8'hA3, 1'b1, 1'b0);
      check("t2_first", {24'd0, rdata}, {24'd0, m_data});
      send_frame(8'h0F, 1'b1, 154);
      model_frame(8'h0F, 1'b1, 1'b1);
      check("t2_second", {24'd0, rdata}, {24'd0, m_data});
      check("t2_rvalid", {31'd0, rvalid}, {31'd0, m_valid});
      check("t2_ovr", ovr_cnt, m_ovr);
      consume();

      // overrun
      send_frame(8'h12, 1'b1, -1);
      model_frame(8'h12, 1'b1, 1'b0);
      send_frame(8'h34, 1'b1, -1);
      model_frame(8'h34, 1'b1, 1'b0);
      check("t3_ovr", ovr_cnt, m_ovr);
      check("t3_rdata", {24'd0, rdata}, {24'd0, m_data});
      consume();
      check("t3_cleared", {31'd0, rvalid}, 32'h0);

      // framing error and break
      send_frame(8'h7E, 1'b0, -1);
      model_frame(8'h7E, 1'b0, 1'b0);
      busy_low = 0;
      rx = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!busy) busy_low++;
         idle(1);
      end
      check("t4_busy_held", busy_low, 0);
      check("t4_ferr", ferr_cnt, m_ferr);
      check("t4_no_rvalid", {31'd0, rvalid}, 32'h0);
      rx = 1'b1;
      waited = 0;
      while (busy && waited < 8) begin
         idle(1);
         waited++;
      end
      check("t4_break_exit", {31'd0, busy}, 32'h0);
      idle(4);
      send_frame(8'hC5, 1'b1, -1);
      model_frame(8'hC5, 1'b1, 1'b0);
      check("t4_after", {24'd0, rdata}, {24'd0, m_data});
      check("t4_after_v", {31'd0, rvalid}, {31'd0, m_valid});
      consume();

      // glitch rejection
      idle(4);
      saw_busy = 1'b0;
      rx = 1'b0;
      for (int i = 0; i < 4; i++) begin
         saw_busy |= busy;
         idle(1);
      end
      rx = 1'b1;
      waited = 0;
      while ((busy || !saw_busy) && waited < 10) begin
         saw_busy |= busy;
         idle(1);
         waited++;
      end
      check("t5_busy_seen", {31'd0, saw_busy}, 32'h1);
      check("t5_busy_low", {31'd0, busy}, 32'h0);
      idle(170);
      check("t5_no_rvalid", {31'd0, rvalid}, 32'h0);
      check("t5_no_ferr", ferr_cnt, m_ferr);

      // randomized frames with random consume and stop-bit faults
      for (int i = 0; i < 10; i++) begin
         d = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 3) != 0);
         gap = int'($urandom_range(1, 20));
         send_frame(d, good, -1);
         model_frame(d, good, 1'b0);
         if (!good) idle(16);
         idle(gap);
         check("rnd_rvalid", {31'd0, rvalid}, {31'd0, m_valid});
         if (m_valid) check("rnd_rdata", {24'd0, rdata}, {24'd0, m_data});
         check("rnd_ferr", ferr_cnt, m_ferr);
         check("rnd_ovr", ovr_cnt, m_ovr);
         if (m_valid && $urandom_range(0, 1) == 1) consume();
      end
      if (m_valid) consume();

      // reset mid-frame
      send_frame(8'h3C, 1'b1, -1);
      model_frame(8'h3C, 1'b1, 1'b0);
      check("t6_pre_rvalid", {31'd0, rvalid}, 32'h1);
      begin
         logic [9:0] bits;
         bits = {1'b1, 8'h5A, 1'b0};
         for (int k = 0; k < 70; k++) begin
            rx = bits[k/16];
            idle(1);
         end
      end
      #3 rst = 1'b0;
      #1;
      m_valid = 1'b0;
      m_data = 8'h00;
      check("t6_rst_rdata", {24'd0, rdata}, {24'd0, m_data});
      check("t6_rst_rvalid", {31'd0, rvalid}, {31'd0, m_valid});
      check("t6_rst_busy", {31'd0, busy}, 32'h0);
      check("t6_rst_ferr", {31'd0, ferr}, 32'h0);
      check("t6_rst_ovr", {31'd0, ovr}, 32'h0);
      rx = 1'b1;
      idle(3);
      rst = 1'b1;
      busy_low = 0;
      for (int i = 0; i < 90; i++) begin
         if (busy || rvalid) busy_low++;
         idle(1);
      end
      check("t6_quiet", busy_low, 0);
      check("t6_ferr", ferr_cnt, m_ferr);
      send_frame(8'h81, 1'b1, -1);
      model_frame(8'h81, 1'b1, 1'b0);
      check("t6_new_rdata", {24'd0, rdata}, {24'd0, m_data});
      check("t6_new_rvalid", {31'd0, rvalid}, {31'd0, m_valid});
      consume();
      check("t6_cleared", {31'd0, rvalid}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Serial-to-parallel UART receiver: oversamples the `rx` line at 16× baud, validates start and stop bits, and delivers each received character through a one-entry holding register on a valid/ready handshake. It is the receive half of the UART, the counterpart to the byte serializer. It feeds the `rdata/rvalid/rready` port that the microcode FSM and the echo path consume.

## Interface
- `frequency`, 66000000: clock frequency in Hz.
- `baudrate`, 115200: line rate in bit/s.
- `data_width`, 8: data bits per frame. Legal range is 5..9.

- `clk`: in, 1. System clock; the only clock.
- `rst`: in, 1. Reset, asynchronous, active-low (0 = reset).
- `rx`: in, 1. Serial line, idle high, asynchronous to `clk`.
- `rdata`: out, `data_width`. Received character, LSB = first data bit.
- `rvalid`: out, 1. `rdata` holds an unconsumed character.
- `rready`: in, 1. Consumer accepts `rdata` in this cycle.
- `ferr`: out, 1. One-cycle pulse when a frame has a stop bit of 0.
- `ovr`: out, 1. One-cycle pulse when a good frame is dropped because the holding register is full.
- `busy`: out, 1. High in every state except IDLE.

## Operation
- **Synchronizer.** `rx` passes through a 2-FF synchronizer. Both flops reset to 1. All logic below uses the synchronized value `rxs`.
- **Tick generator.** `DIV = (frequency + 8*baudrate) / (16*baudrate)`, rounded to nearest; DIV ≥ 1 is required. The generator pulses `tick` for one cycle every DIV clocks. Its counter restarts when IDLE detects a start edge, so phase aligns to the edge.
- **Oversampling counter.** `os` is 4 bits and advances on each `tick`, wrapping 15→0. The mid-bit sample is taken when `os == 7` at a tick.
- **IDLE.** `rxs == 0` moves to START, with `os = 0` and `bitcnt = 0`.
- **START.** At mid-bit: `rxs == 0` moves to DATA; `rxs == 1` is a glitch and returns to IDLE with no flag.
- **DATA.** At each mid-bit, shift `rxs` into the MSB of the shift register (right shift, LSB first). After `data_width` samples, move to STOP.
- **STOP.** At mid-bit:
  - `rxs == 1`: a good frame. Move to IDLE immediately, so the next start edge can arrive within half a bit.
  - `rxs == 0`: pulse `ferr`, discard the frame, move to BREAK.
- **BREAK.** Wait for `rxs == 1`, then move to IDLE. A held-low line produces exactly one `ferr`.
- **Holding register**, evaluated on the good-frame cycle:
  - `rvalid == 0`: load `rdata`, set `rvalid`.
  - `rvalid == 1 && rready == 1`: load the new data; `rvalid` stays 1. No overrun.
  - `rvalid == 1 && rready == 0`: keep the old `rdata`, drop the new frame, pulse `ovr`.
- **Handshake.** Without a new frame, `rvalid && rready` clears `rvalid` on the next edge. `rready` while `rvalid == 0` has no effect. `rdata` is stable while `rvalid && !rready`.
- **Reset values.** `rdata = 0`, `rvalid = 0`, `ferr = 0`, `ovr = 0`, `busy = 0`, state IDLE. Reset mid-frame abandons the frame; after release, a new frame needs a fresh falling edge.

## Timing
- Start-edge detection lags the `rx` pin by 2–3 clocks (synchronizer).
- The start sample falls 8·DIV clocks after detection, and each later sample 16·DIV clocks after the previous one.
- `rvalid` rises, or `ferr`/`ovr` pulses, on the clock edge following the stop-bit sample tick.
- End-to-end latency from the falling start edge on the pin to `rvalid` is about `(16·(data_width+1)+8)·DIV + 3` clocks.
- Tolerated baud mismatch is ±3 % for 8N1.
- All outputs are registered; there is no combinational path from `rx` or `rready` to any output.

## Structure
- Package `uart_pkg` holds:
  - the state encoding: IDLE, START, DATA, STOP, BREAK;
  - the `OS_MID = 7` and `OS_LAST = 15` constants;
  - the DIV computation and its counter width, `$clog2(DIV)` with a minimum of 1.
- One sub-module, `uart_baud_tick`, with inputs `clk`, `rst`, `restart` and output `tick`, parameterized by DIV. The serializer reuses the same sub-module.

## Test plan
Bench parameters: `frequency=1843200`, `baudrate=115200`, so DIV = 1 and one bit = 16 clocks.
1. **Single frame.** Send 8N1 frame 0x55, hold `rready = 0`. Expect `rvalid` = 1 and `rdata` = 0x55 within 155±3 clocks of the start edge; no `ferr`/`ovr`. Pulse `rready` and expect `rvalid` = 0 on the next edge.
2. **Back-to-back with simultaneous accept.** Send 0xA3 then 0x0F back-to-back. Assert `rready` in the exact cycle the second frame completes. Expect `rdata` to go 0xA3 → 0x0F with `rvalid` held at 1 and no `ovr`.
3. **Overrun.** Send 0x12, 0x34 with `rready = 0`. Expect `ovr` to pulse once, then `rdata` = 0x12 when `rready` is raised, after which `rvalid` = 0.
4. **Framing error and break.** Send 0x7E with stop bit = 0, then hold `rx` low for 100 clocks. Expect exactly one `ferr` pulse, no `rvalid`, and `busy` = 1 until `rx` returns high. A following 0xC5 frame must be received correctly.
5. **Glitch rejection.** Drive a 4-clock low glitch on idle `rx`. Expect return to IDLE, `busy` low within 10 clocks, and no `rvalid`/`ferr`.
6. **Reset mid-frame.** Assert `rst = 0` during bit 3 of a frame. Expect all outputs at 0 immediately (asynchronous). After release, the remaining bits of the interrupted frame on a high line produce nothing, and a new 0x81 frame is received correctly.
